// File: rtl/simon_key_schedule.sv
// SIMON key expansion: loads the M-word master key, then generates one round key per clock
// into an internal table. The table is read through a registered, index-addressed port.
module simon_key_schedule #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 4,
    parameter int unsigned T = 32,
    parameter logic [61:0] Z = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 start,
    input  logic [M*N-1:0]       key_in,
    output logic                 busy,
    output logic                 done,
    input  logic [$clog2(T):0]   rd_idx,
    output logic [N-1:0]         rd_key
);

    localparam int unsigned IW = $clog2(T);
    localparam int unsigned RW = IW + 1;

    typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [5:0]     zi_q, zi_d;
    logic [N-1:0]   key_q [T];
    logic [N-1:0]   key_d [T];
    logic [N-1:0]   rd_key_q, rd_key_d;
    logic           load, expand;
    logic [N-1:0]   prev, tmp, new_key;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StExpand;
            StExpand: if (idx_q == IW'(T - 1)) state_d = StDone;
            StDone:   if (start) state_d = StExpand;
            default:  state_d = StIdle;
        endcase
    end

    // start during expansion is deliberately ignored
    always_comb begin
        busy   = (state_q == StExpand);
        done   = (state_q == StDone);
        expand = (state_q == StExpand);
        load   = start && (state_q != StExpand);
    end

    always_comb begin
        prev = key_q[idx_q - IW'(1)];
        tmp  = {prev[2:0], prev[N-1:3]};
        if (M == 4) begin
            tmp = tmp ^ key_q[idx_q - IW'(3)];
        end
        tmp     = tmp ^ {tmp[0], tmp[N-1:1]};
        new_key = ~key_q[idx_q - IW'(M)] ^ tmp ^ {{(N-1){1'b0}}, Z[6'd61 - zi_q]} ^ N'(3);
    end

    // zi tracks (idx - M) mod 62 so no divider is needed
    always_comb begin
        idx_d = idx_q;
        zi_d  = zi_q;
        key_d = key_q;
        if (load) begin
            for (int j = 0; j < int'(M); j++) begin
                key_d[j] = key_in[j*N +: N];
            end
            idx_d = IW'(M);
            zi_d  = 6'd0;
        end else if (expand) begin
            key_d[idx_q] = new_key;
            idx_d        = idx_q + IW'(1);
            zi_d         = (zi_q == 6'd61) ? 6'd0 : zi_q + 6'd1;
        end
    end

    always_comb begin
        rd_key_d = '0;
        if (rd_idx < RW'(T)) begin
            rd_key_d = key_q[rd_idx[IW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            idx_q    <= '0;
            zi_q     <= '0;
            rd_key_q <= '0;
            for (int i = 0; i < int'(T); i++) begin
                key_q[i] <= '0;
            end
        end else begin
            idx_q    <= idx_d;
            zi_q     <= zi_d;
            rd_key_q <= rd_key_d;
            key_q    <= key_d;
        end
    end

    assign rd_key = rd_key_q;

endmodule

// File: doc/simon_key_schedule.md
Name: simon_key_schedule

Overview:
Iterative SIMON key-expansion stage sitting directly upstream of the round controller. It loads the M-word master key, generates the remaining T-M round keys at one per clock, and stores all T keys in an internal register file. It asserts done when the whole table is valid. The consumer reads any round key by index through a registered read port, ascending for encrypt and descending for decrypt.

Parameters:
N, 16, word size in bits
M, 4, number of key words (legal: 2, 3, 4)
T, 32, number of rounds / round keys
Z, 62'b11111010001001010110000111001101111101000100101011000011100110, round-constant sequence; the leftmost character is z[0]

Ports:
clk  input  1  clock
nReset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to expand key_in
key_in  input  M*N  master key; word j = key_in[(j+1)*N-1 : j*N], word 0 = k[0]
busy  output  1  high while expansion is in progress
done  output  1  high while the key table is complete and valid
rd_idx  input  $clog2(T)+1  round-key index to read
rd_key  output  N  registered round key k[rd_idx]

Behaviour:
- Reset (async, nReset low): state IDLE; busy=0, done=0, rd_key=0; write index=0; key table cleared to 0.
- States: IDLE, EXPAND, DONE.
- IDLE:
  - start=1 at edge E0 loads k[0..M-1] from key_in, sets idx=M and moves to EXPAND.
  - start=0 stays in IDLE.
- EXPAND: one key per edge.
  - tmp = ROR(k[idx-1],3).
  - If M==4: tmp ^= k[idx-3]. For M=2 or 3 there is no extra term.
  - tmp ^= ROR(tmp,1).
  - k[idx] = ~k[idx-M] ^ tmp ^ {N-1 zeros, z[(idx-M) mod 62]} ^ 3.
  - idx increments each cycle. The edge that writes k[T-1] moves to DONE.
- Latency: busy=1 from E0+1 through E0+(T-M). done=1 from edge E0+(T-M) onward. Defaults: 28 cycles.
- DONE:
  - done is held until the next start.
  - start=1 reloads key_in exactly as in IDLE, and done falls on that same edge.
- start while in EXPAND is ignored. The current expansion completes unchanged.
- key_in is sampled only on the start edge. Later changes to key_in have no effect.
- All arithmetic is mod 2^N. ROR is a rotation within N bits. The z index wraps at 62.
- Read port:
  - rd_key <= k[rd_idx] on every edge, so rd_key has 1-cycle latency.
  - rd_idx >= T gives rd_key <= 0.
  - Reads are legal in any state. Contents are guaranteed correct only when done=1.
  - A read of the index being written in the same cycle returns the old value.
- Reset mid-expansion aborts immediately. The table clears and done=0. A new start is required.
- Round keys are never exposed combinationally; the table is the only source.

Test Plan:
1. Reset, then start with key_in = {16'h1918,16'h1110,16'h0908,16'h0100} (M=4, N=16, T=32):
   - busy rises 1 cycle after start.
   - done rises exactly 28 cycles after the start edge.
   - rd_idx=4 gives rd_key=16'h71C3 one cycle later.
2. After case 1, sweep rd_idx 0..31:
   - indices 0..3 return 0100, 0908, 1110, 1918;
   - all 32 keys match the software SIMON32/64 model;
   - driving the rounds with plaintext 6565_6877 yields ciphertext c69b_e9bb.
3. Assert start again 10 cycles into expansion with a different key_in:
   - it is ignored;
   - done still rises at cycle 28;
   - the table matches case 1.
4. In DONE, start with key_in = 0:
   - done drops on the start edge and re-asserts 28 cycles later;
   - k[4] = ~0 ^ 0 ^ 1 ^ 3 = 16'hFFFD.
5. Drop nReset mid-expansion at cycle 15:
   - busy=0, done=0 and rd_key=0 immediately (async);
   - rd_idx=2 reads 0 after reset is released;
   - a new start completes correctly.
6. With rd_idx=32 and rd_idx=63, rd_key=0 in both IDLE and DONE.
